// File: rtl/ddr3_init_pkg.sv
// Shared types and constants for the DDR3 power-up sequencer.
// Command encodings are {ras_n, cas_n, we_n}.
package ddr3_init_pkg;

  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_MRS  = 3'b000;
  localparam logic [2:0] CMD_ZQCL = 3'b110;

  // A10 high selects ZQCL (long calibration) rather than ZQCS
  localparam logic [13:0] ZQCL_ADDR = 14'h0400;

  typedef enum logic [3:0] {
    StIdle,
    StCkeWait,
    StTxpr,
    StMr2,
    StMr3,
    StMr1,
    StMr0,
    StZqcl,
    StZqWait,
    StDone
  } state_e;

  // Zero-cycle waits are stretched to one cycle so strobes stay distinct
  function automatic int unsigned clamp_min1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d,
                                              input int unsigned e);
    int unsigned m;
    m = clamp_min1(a);
    if (clamp_min1(b) > m) m = clamp_min1(b);
    if (clamp_min1(c) > m) m = clamp_min1(c);
    if (clamp_min1(d) > m) m = clamp_min1(d);
    if (clamp_min1(e) > m) m = clamp_min1(e);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ddr3_init_seq_if.sv
// Handshake with the init controller plus the command/PHY-side bus of the sequencer.
interface ddr3_init_seq_if;

  logic        mem_rst_n;
  logic        init_start;
  logic        ddr_init_done;
  logic        cke;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [2:0]  ba;
  logic [13:0] addr;

  modport master (
    output mem_rst_n,
    output init_start,
    input  ddr_init_done,
    input  cke,
    input  cmd_valid,
    input  cmd,
    input  ba,
    input  addr
  );

  modport slave (
    input  mem_rst_n,
    input  init_start,
    output ddr_init_done,
    output cke,
    output cmd_valid,
    output cmd,
    output ba,
    output addr
  );

endinterface

// File: rtl/ddr3_init_timer.sv
// Loadable down-counter; holds at zero and flags expiry while it sits there.
module ddr3_init_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_value,
  output logic             o_expire
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expire = (count_q == '0);

endmodule

// File: rtl/ddr3_init_seq.sv
// DDR3 power-up sequencer: CKE wait, tXPR, MR2/MR3/MR1/MR0, ZQCL, tZQinit, then done.
// Command strobes are registered and issued on the edge that enters each command state.
module ddr3_init_seq
  import ddr3_init_pkg::*;
#(
  parameter int unsigned P_TCKE_WAIT = 50000,
  parameter int unsigned P_TXPR      = 27,
  parameter int unsigned P_TMRD      = 4,
  parameter int unsigned P_TMOD      = 12,
  parameter int unsigned P_TZQINIT   = 512,
  parameter logic [13:0] P_MR0       = 14'h0520,
  parameter logic [13:0] P_MR1       = 14'h0044,
  parameter logic [13:0] P_MR2       = 14'h0008,
  parameter logic [13:0] P_MR3       = 14'h0000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  ddr3_init_seq_if.slave  init_if
);

  localparam int unsigned TimerW = timer_width(P_TCKE_WAIT, P_TXPR, P_TMRD, P_TMOD, P_TZQINIT);

  // Strobe-to-strobe waits load N-1 because the strobe itself lands on the expiry edge;
  // CKE and done are one edge after expiry, so those load the full N.
  localparam logic [TimerW-1:0] LdCkeWait = TimerW'(clamp_min1(P_TCKE_WAIT));
  localparam logic [TimerW-1:0] LdTxpr    = TimerW'(clamp_min1(P_TXPR) - 1);
  localparam logic [TimerW-1:0] LdTmrd    = TimerW'(clamp_min1(P_TMRD) - 1);
  localparam logic [TimerW-1:0] LdTmod    = TimerW'(clamp_min1(P_TMOD) - 1);
  localparam logic [TimerW-1:0] LdTzqinit = TimerW'(clamp_min1(P_TZQINIT));

  state_e      state_q, state_d;
  logic        cke_q, cke_d;
  logic        done_q, done_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [2:0]  ba_q, ba_d;
  logic [13:0] addr_q, addr_d;

  logic              tmr_load;
  logic [TimerW-1:0] tmr_value;
  logic              tmr_expire;

  ddr3_init_timer #(
    .Width (TimerW)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (tmr_load),
    .i_value  (tmr_value),
    .o_expire (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    cke_d       = cke_q;
    done_d      = done_q;
    cmd_valid_d = 1'b0;
    cmd_d       = CMD_NOP;
    ba_d        = ba_q;
    addr_d      = addr_q;
    tmr_load    = 1'b0;
    tmr_value   = '0;

    if (!init_if.mem_rst_n) begin
      state_d  = StIdle;
      cke_d    = 1'b0;
      done_d   = 1'b0;
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (init_if.init_start) begin
            state_d   = StCkeWait;
            tmr_load  = 1'b1;
            tmr_value = LdCkeWait;
          end
        end
        StCkeWait: begin
          if (tmr_expire) begin
            state_d   = StTxpr;
            cke_d     = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = LdTxpr;
          end
        end
        StTxpr, StMr2, StMr3, StMr1: begin
          if (tmr_expire) begin
            cmd_valid_d = 1'b1;
            cmd_d       = CMD_MRS;
            tmr_load    = 1'b1;
            tmr_value   = LdTmrd;
            unique case (state_q)
              StTxpr:  begin state_d = StMr2; ba_d = 3'd2; addr_d = P_MR2; end
              StMr2:   begin state_d = StMr3; ba_d = 3'd3; addr_d = P_MR3; end
              StMr3:   begin state_d = StMr1; ba_d = 3'd1; addr_d = P_MR1; end
              default: begin
                state_d   = StMr0;
                ba_d      = 3'd0;
                addr_d    = P_MR0;
                tmr_value = LdTmod;
              end
            endcase
          end
        end
        StMr0: begin
          if (tmr_expire) begin
            state_d     = StZqcl;
            cmd_valid_d = 1'b1;
            cmd_d       = CMD_ZQCL;
            ba_d        = 3'd0;
            addr_d      = ZQCL_ADDR;
            tmr_load    = 1'b1;
            tmr_value   = LdTzqinit;
          end
        end
        StZqcl: begin
          state_d = StZqWait;
        end
        StZqWait: begin
          if (tmr_expire) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cke_q       <= 1'b0;
      done_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      ba_q        <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      cke_q       <= cke_d;
      done_q      <= done_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      addr_q      <= addr_d;
    end
  end

  assign init_if.ddr_init_done = done_q;
  assign init_if.cke           = cke_q;
  assign init_if.cmd_valid     = cmd_valid_q;
  assign init_if.cmd           = cmd_q;
  assign init_if.ba            = ba_q;
  assign init_if.addr          = addr_q;

endmodule
